// File: rtl/quad_decoder.sv
// Purpose: quadrature A/B decoder producing step/dir pulses and an n-bit wrapping position count.
// Latency: an a/b change stable before edge k updates o/step/dir at edge k+2.
// Backpressure: none; pins are sampled every cycle and en only gates counting, never phase tracking.
module quad_decoder #(
    parameter int unsigned       n    = 4,
    parameter logic [n-1:0]      INIT = n'(4'b1010)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         a,
    input  logic         b,
    output logic [n-1:0] o,
    output logic         step,
    output logic         dir,
    output logic         err
);

    // Start-up sequence: two cycles to fill the synchronizer, one to prime prev.
    typedef enum logic [1:0] {
        WAIT0 = 2'd0,
        WAIT1 = 2'd1,
        PRIME = 2'd2,
        TRACK = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   s1_q, s1_d;
    logic [1:0]   s2_q, s2_d;
    logic [1:0]   prev_q, prev_d;
    logic [n-1:0] o_q, o_d;
    logic         step_q, step_d;
    logic         dir_q, dir_d;
    logic         err_q, err_d;

    logic         is_up;
    logic         is_down;
    logic         is_bad;
    logic         tracking;

    // State register for all flops; reset also restarts the start-up sequence.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WAIT0;
            s1_q    <= 2'b00;
            s2_q    <= 2'b00;
            prev_q  <= 2'b00;
            o_q     <= INIT;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            o_q     <= o_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    // Two-flop synchronizer for the asynchronous encoder pins, bits ordered {a,b}.
    always_comb begin
        s1_d = {a, b};
        s2_d = s1_q;
    end

    // Start-up FSM: walk to TRACK one state per cycle, then stay there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT0:   state_d = WAIT1;
            WAIT1:   state_d = PRIME;
            PRIME:   state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = WAIT0;
        endcase
    end

    // Classify the prev -> current Gray transition; equal phases classify as nothing.
    always_comb begin
        is_up   = 1'b0;
        is_down = 1'b0;
        is_bad  = 1'b0;
        case ({prev_q, s2_q})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_up   = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: is_down = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: is_bad  = 1'b1;
            default: ;
        endcase
    end

    // Count, pulse and error update; clr overrides the count and error but not step/dir.
    always_comb begin
        tracking = (state_q == TRACK);
        prev_d   = prev_q;
        o_d      = o_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        err_d    = err_q;

        // prev follows s2 from PRIME onward, regardless of en or illegal steps.
        if (state_q == PRIME || tracking) begin
            prev_d = s2_q;
        end

        if (tracking && en && (is_up || is_down)) begin
            step_d = 1'b1;
            dir_d  = is_down;
            o_d    = is_up ? (o_q + 1'b1) : (o_q - 1'b1);
        end

        if (tracking && is_bad) begin
            err_d = 1'b1;
        end

        if (clr) begin
            o_d   = INIT;
            err_d = 1'b0;
        end
    end

    assign o    = o_q;
    assign step = step_q;
    assign dir  = dir_q;
    assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Purpose: directed self-checking bench for quad_decoder (n=4, INIT=4'hA).
// Latency: checks the two-cycle pin-to-output path on every driven transition.
// Backpressure: not applicable; stimulus is cycle-driven.
module tb_quad_decoder;

    logic       clk;
    logic       reset;
    logic       en;
    logic       clr;
    logic       a;
    logic       b;
    logic [3:0] o;
    logic       step;
    logic       dir;
    logic       err;

    int n_checks;
    int n_errors;
    int step_cnt;
    int cnt_snap;

    quad_decoder #(
        .n    (4),
        .INIT (4'hA)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (clr),
        .a     (a),
        .b     (b),
        .o     (o),
        .step  (step),
        .dir   (dir),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every step pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (step === 1'b1) step_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] ab);
        a     = ab[1];
        b     = ab[0];
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick();
    endtask

    // Drive a new phase and hold it 4 clocks; the pulse must land exactly on the third edge.
    task automatic drive_ab(input string tag, input logic [1:0] ab, input logic exp_step);
        a = ab[1];
        b = ab[0];
        tick();
        tick();
        check({tag, ".early"}, step, 1'b0);
        tick();
        check({tag, ".pulse"}, step, exp_step);
        tick();
        check({tag, ".after"}, step, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        step_cnt = 0;
        en       = 1'b1;
        clr      = 1'b0;
        a        = 1'b1;
        b        = 1'b1;

        // 1. Reset with pins at 11, then idle.
        reset = 1'b0;
        tick();
        check("rst.o",    o,    4'hA);
        check("rst.step", step, 1'b0);
        check("rst.dir",  dir,  1'b0);
        check("rst.err",  err,  1'b0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("idle.o",     o,        4'hA);
        check("idle.steps", step_cnt, 0);
        check("idle.err",   err,      1'b0);

        // 2. One full up cycle from 00.
        do_reset(2'b00);
        drive_ab("up1", 2'b01, 1'b1);
        check("up1.o", o, 4'hB);
        drive_ab("up2", 2'b11, 1'b1);
        drive_ab("up3", 2'b10, 1'b1);
        drive_ab("up4", 2'b00, 1'b1);
        check("up.o",     o,        4'hE);
        check("up.dir",   dir,      1'b0);
        check("up.steps", step_cnt, 4);

        // 3. Wrap up through F -> 0, then down 0 -> F.
        drive_ab("upF", 2'b01, 1'b1);
        check("upF.o", o, 4'hF);
        drive_ab("wrapup", 2'b11, 1'b1);
        check("wrapup.o",   o,   4'h0);
        check("wrapup.err", err, 1'b0);
        drive_ab("wrapdn", 2'b01, 1'b1);
        check("wrapdn.o",   o,   4'hF);
        check("wrapdn.dir", dir, 1'b1);
        check("wrapdn.err", err, 1'b0);

        // 4. Illegal double-bit jump 01 -> 10, then clear.
        drive_ab("jump", 2'b10, 1'b0);
        check("jump.err", err, 1'b1);
        check("jump.o",   o,   4'hF);
        check("jump.dir", dir, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check("jump.sticky", err, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr.o",   o,   4'hA);
        check("clr.err", err, 1'b0);

        // 5. Disabled counting keeps tracking phase, then one enabled step.
        en = 1'b0;
        drive_ab("dis1", 2'b00, 1'b0);
        drive_ab("dis2", 2'b01, 1'b0);
        drive_ab("dis3", 2'b11, 1'b0);
        check("dis.o", o, 4'hA);
        en = 1'b1;
        drive_ab("en1", 2'b10, 1'b1);
        check("en1.o",   o,   4'hB);
        check("en1.dir", dir, 1'b0);
        check("en1.err", err, 1'b0);

        // clr on the same edge as a step: count reloads, step/dir still report it.
        a = 1'b0;
        b = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("prio.o",    o,    4'hA);
        check("prio.step", step, 1'b1);
        check("prio.dir",  dir,  1'b0);
        check("prio.err",  err,  1'b0);
        tick();
        check("prio.after", step, 1'b0);

        // 6. Set err and dir=1, then reset while a down transition is in flight.
        drive_ab("jump2", 2'b11, 1'b0);
        check("jump2.err", err, 1'b1);
        drive_ab("dn9", 2'b01, 1'b1);
        check("dn9.o",   o,   4'h9);
        check("dn9.dir", dir, 1'b1);
        a = 1'b0;
        b = 1'b0;
        tick();
        reset = 1'b0;
        a     = 1'b0;
        b     = 1'b1;
        tick();
        check("midrst.o",    o,    4'hA);
        check("midrst.step", step, 1'b0);
        check("midrst.dir",  dir,  1'b0);
        check("midrst.err",  err,  1'b0);
        reset    = 1'b1;
        cnt_snap = step_cnt;
        for (int i = 0; i < 6; i++) tick();
        check("restart.steps", step_cnt, cnt_snap);
        check("restart.o",     o,        4'hA);
        drive_ab("resume", 2'b11, 1'b1);
        check("resume.o", o, 4'hB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
